// File: rtl/sme_pkg.sv
// Shared constants, default depths and FSM state type for the string-match engine.
package sme_pkg;

  localparam int DEF_STR_DEPTH = 32;
  localparam int DEF_PAT_DEPTH = 8;
  localparam int DEF_CHAR_W    = 8;

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_DOT   = 8'h2E;
  localparam logic [7:0] CH_HEAD  = 8'h5E;
  localparam logic [7:0] CH_TAIL  = 8'h24;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_S,
    LOAD_P,
    SEARCH,
    DONE
  } state_t;

endpackage

// File: rtl/sme_cand_cmp.sv
// Compares the string window at one candidate position against the pattern body;
// '.' in the body matches any character. Anchors are handled by the caller.
module sme_cand_cmp
  import sme_pkg::*;
#(
  parameter int PAT_DEPTH = DEF_PAT_DEPTH,
  parameter int CHAR_W    = DEF_CHAR_W,
  parameter int PW        = $clog2(PAT_DEPTH + 1)
) (
  input  logic [PAT_DEPTH-1:0][CHAR_W-1:0] win,
  input  logic [PAT_DEPTH-1:0][CHAR_W-1:0] body,
  input  logic [PW-1:0]                    body_len,
  output logic                             hit
);

  always_comb begin
    hit = 1'b1;
    for (int k = 0; k < PAT_DEPTH; k++) begin
      if (PW'(k) < body_len && body[k] != CHAR_W'(CH_DOT) && body[k] != win[k])
        hit = 1'b0;
    end
  end

endmodule

// File: rtl/sme_param.sv
// Parametrised string-match engine: one candidate position per cycle, string kept
// across patterns. Define SME_ALL_MATCH_EN to report every match plus match_last.
module sme_param
  import sme_pkg::*;
#(
  parameter int STR_DEPTH = DEF_STR_DEPTH,
  parameter int PAT_DEPTH = DEF_PAT_DEPTH,
  parameter int CHAR_W    = DEF_CHAR_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [CHAR_W-1:0]            chardata,
  input  logic                         isstring,
  input  logic                         ispattern,
  output logic                         busy,
  output logic                         valid,
  output logic                         match,
  output logic [$clog2(STR_DEPTH)-1:0] match_index,
  output logic                         overflow
`ifdef SME_ALL_MATCH_EN
  ,
  output logic                         match_last
`endif
);

  localparam int IW  = $clog2(STR_DEPTH);
  localparam int LW  = $clog2(STR_DEPTH + 1);
  localparam int PIW = $clog2(PAT_DEPTH);
  localparam int PW  = $clog2(PAT_DEPTH + 1);
  localparam int XW  = $clog2(STR_DEPTH + PAT_DEPTH + 1) + 1;

  state_t state;

  logic [CHAR_W-1:0] str_mem [STR_DEPTH];
  logic [CHAR_W-1:0] pat_mem [PAT_DEPTH];
  logic [LW-1:0]     str_len;
  logic [LW-1:0]     pos;
  logic [PW-1:0]     pat_len;

  logic              str_new, pat_new, str_we, pat_we;
  logic [IW-1:0]     str_waddr;
  logic [PIW-1:0]    pat_waddr;

  always_comb begin
    str_new   = (state != LOAD_S);
    pat_new   = (state != LOAD_P);
    str_waddr = str_new ? '0 : IW'(str_len);
    pat_waddr = pat_new ? '0 : PIW'(pat_len);
    str_we    = isstring && (str_new || str_len < LW'(STR_DEPTH));
    pat_we    = !isstring && ispattern && (pat_new || pat_len < PW'(PAT_DEPTH));
  end

  // Character storage carries no reset: contents beyond the lengths are never trusted.
  always_ff @(posedge clk) begin
    if (str_we) str_mem[str_waddr] <= chardata;
    if (pat_we) pat_mem[pat_waddr] <= chardata;
  end

  logic          head, tail, dollar_only;
  logic [PW-1:0] body_len;

  always_comb begin
    head        = (pat_len != '0) && (pat_mem[0] == CHAR_W'(CH_HEAD));
    tail        = (pat_len != '0) && (pat_mem[PIW'(pat_len - PW'(1))] == CHAR_W'(CH_TAIL));
    body_len    = pat_len - PW'(head) - PW'(tail);
    dollar_only = tail && !head && (body_len == '0);
  end

  logic [PAT_DEPTH-1:0][CHAR_W-1:0] win, body;
  logic [XW-1:0]                    widx;

  always_comb begin
    win  = '0;
    body = '0;
    widx = '0;
    for (int k = 0; k < PAT_DEPTH; k++) begin
      widx = XW'(pos) + XW'(k);
      if (widx < XW'(STR_DEPTH)) win[k] = str_mem[IW'(widx)];
      if (!head) body[k] = pat_mem[PIW'(k)];
      else if (k + 1 < PAT_DEPTH) body[k] = pat_mem[PIW'(k + 1)];
    end
  end

  logic cmp_hit;

  sme_cand_cmp #(
    .PAT_DEPTH (PAT_DEPTH),
    .CHAR_W    (CHAR_W),
    .PW        (PW)
  ) u_cand_cmp (
    .win      (win),
    .body     (body),
    .body_len (body_len),
    .hit      (cmp_hit)
  );

  logic [XW-1:0]     end_x, len_x;
  logic [CHAR_W-1:0] prev_char, next_char;
  logic              head_ok, tail_ok, in_range, last_pos, cand_hit;
  logic [IW-1:0]     hit_index;

  // A lone '$' only fires at the true end and reports the last character's index.
  always_comb begin
    len_x     = XW'(str_len);
    end_x     = XW'(pos) + XW'(body_len);
    prev_char = (pos == '0) ? CHAR_W'(CH_SPACE) : str_mem[IW'(pos - LW'(1))];
    next_char = (end_x < XW'(STR_DEPTH)) ? str_mem[IW'(end_x)] : '0;
    head_ok   = (prev_char == CHAR_W'(CH_SPACE));
    tail_ok   = (end_x == len_x) || (!dollar_only && next_char == CHAR_W'(CH_SPACE));
    in_range  = (end_x <= len_x);
    last_pos  = (end_x >= len_x);
    cand_hit  = in_range && cmp_hit && (!head || head_ok) && (!tail || tail_ok);
    hit_index = (dollar_only && pos != '0) ? IW'(pos - LW'(1)) : IW'(pos);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      str_len     <= '0;
      pat_len     <= '0;
      pos         <= '0;
      busy        <= 1'b0;
      valid       <= 1'b0;
      match       <= 1'b0;
      match_index <= '0;
      overflow    <= 1'b0;
`ifdef SME_ALL_MATCH_EN
      match_last  <= 1'b0;
`endif
    end else begin
      valid <= 1'b0;
`ifdef SME_ALL_MATCH_EN
      match_last <= 1'b0;
`endif
      if (isstring) begin
        state <= LOAD_S;
        busy  <= 1'b0;
        if (str_new) begin
          str_len  <= LW'(1);
          overflow <= 1'b0;
        end else if (str_len < LW'(STR_DEPTH)) begin
          str_len <= str_len + LW'(1);
        end else begin
          overflow <= 1'b1;
        end
      end else if (ispattern) begin
        state <= LOAD_P;
        busy  <= 1'b0;
        if (pat_new) pat_len <= PW'(1);
        else if (pat_len < PW'(PAT_DEPTH)) pat_len <= pat_len + PW'(1);
        else overflow <= 1'b1;
      end else begin
        case (state)
          LOAD_S: state <= IDLE;
          LOAD_P: begin
            state <= SEARCH;
            busy  <= 1'b1;
            pos   <= '0;
          end
          SEARCH: begin
`ifdef SME_ALL_MATCH_EN
            if (cand_hit || last_pos) begin
              valid       <= 1'b1;
              match       <= cand_hit;
              match_index <= cand_hit ? hit_index : '0;
            end
            if (last_pos) begin
              match_last <= 1'b1;
              busy       <= 1'b0;
              state      <= DONE;
            end else begin
              pos <= pos + LW'(1);
            end
`else
            if (cand_hit || last_pos) begin
              valid       <= 1'b1;
              match       <= cand_hit;
              match_index <= cand_hit ? hit_index : '0;
              busy        <= 1'b0;
              state       <= DONE;
            end else begin
              pos <= pos + LW'(1);
            end
`endif
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sme_param.sv
// Scoreboard bench for sme_param; expected results come from constants or a
// behavioural model of the matcher and are popped as valid strobes appear.
module tb_sme_param;

  localparam int STR_DEPTH = 32;
  localparam int PAT_DEPTH = 8;
  localparam int IW        = $clog2(STR_DEPTH);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    chardata = '0;
  logic          isstring = 1'b0;
  logic          ispattern = 1'b0;
  logic          busy, valid, match, overflow;
  logic [IW-1:0] match_index;
`ifdef SME_ALL_MATCH_EN
  logic          match_last;
`endif

  sme_param #(.STR_DEPTH(STR_DEPTH), .PAT_DEPTH(PAT_DEPTH), .CHAR_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .chardata    (chardata),
    .isstring    (isstring),
    .ispattern   (ispattern),
    .busy        (busy),
    .valid       (valid),
    .match       (match),
    .match_index (match_index),
    .overflow    (overflow)
`ifdef SME_ALL_MATCH_EN
    ,
    .match_last  (match_last)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit m;
    int idx;
    bit last;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fails  = 0;
  byte  mstr[STR_DEPTH];
  byte  mpat[PAT_DEPTH];
  int   mlen = 0;
  int   mplen = 0;
  bit   movf = 0;
  bit   last_m = 0;
  int   last_idx = 0;

  task automatic send_schar(input byte c, input bit first);
    @(negedge clk);
    isstring = 1'b1; ispattern = 1'b0; chardata = c;
    if (first) begin mlen = 0; movf = 0; end
    if (mlen < STR_DEPTH) begin mstr[mlen] = c; mlen++; end
    else movf = 1;
  endtask

  task automatic send_pchar(input byte c, input bit first);
    @(negedge clk);
    isstring = 1'b0; ispattern = 1'b1; chardata = c;
    if (first) mplen = 0;
    if (mplen < PAT_DEPTH) begin mpat[mplen] = c; mplen++; end
    else movf = 1;
  endtask

  task automatic drive_string(input string s);
    for (int i = 0; i < s.len(); i++) send_schar(s[i], i == 0);
    @(negedge clk);
    isstring = 1'b0; chardata = '0;
  endtask

  task automatic drive_pattern(input string p);
    for (int i = 0; i < p.len(); i++) send_pchar(p[i], i == 0);
  endtask

  function automatic int body_len();
    int h, t;
    h = (mplen > 0 && mpat[0] == 8'h5E) ? 1 : 0;
    t = (mplen > 0 && mpat[mplen-1] == 8'h24) ? 1 : 0;
    return mplen - h - t;
  endfunction

  task automatic push_model();
    int  h, t, L, lastp;
    bit  ok, dol, any_hit, last_hit;
    byte c;
    h = (mplen > 0 && mpat[0] == 8'h5E) ? 1 : 0;
    t = (mplen > 0 && mpat[mplen-1] == 8'h24) ? 1 : 0;
    L = mplen - h - t;
    dol = (t == 1) && (h == 0) && (L == 0);
    lastp = mlen - L;
    any_hit = 0; last_hit = 0;
    for (int p = 0; p <= lastp; p++) begin
      ok = 1;
      for (int k = 0; k < L; k++) begin
        c = mpat[h+k];
        if (c != 8'h2E && c != mstr[p+k]) ok = 0;
      end
      if (h == 1 && p > 0 && mstr[p-1] != 8'h20) ok = 0;
      if (t == 1) begin
        if (dol) begin
          if (p != mlen) ok = 0;
        end else if (p + L != mlen && mstr[p+L] != 8'h20) ok = 0;
      end
      if (ok) begin
`ifdef SME_ALL_MATCH_EN
        sb.push_back('{1'b1, dol ? ((p > 0) ? p - 1 : 0) : p, p == lastp});
        if (p == lastp) last_hit = 1;
`else
        if (!any_hit) sb.push_back('{1'b1, dol ? ((p > 0) ? p - 1 : 0) : p, 1'b1});
`endif
        any_hit = 1;
      end
    end
`ifdef SME_ALL_MATCH_EN
    if (!last_hit) sb.push_back('{1'b0, 0, 1'b1});
`else
    if (!any_hit) sb.push_back('{1'b0, 0, 1'b1});
`endif
  endtask

  // First-match builds use the hand-derived result; all-match builds use the model list.
  task automatic expect_result(input bit m, input int idx);
`ifdef SME_ALL_MATCH_EN
    push_model();
`else
    sb.push_back('{m, idx, 1'b1});
`endif
  endtask

  task automatic run_search(input string tag);
    int   cyc, bound;
    exp_t e;
    bound = mlen - body_len() + 2;
    if (bound < 2) bound = 2;
    @(negedge clk);
    isstring = 1'b0; ispattern = 1'b0; chardata = '0;
    cyc = 0;
    while (sb.size() > 0 && cyc < bound + 4) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        n_checks++;
        if (busy !== 1'b1) begin n_fails++; $display("[TB] FAIL %s busy: got %b expected 1", tag, busy); end
      end
      if (valid === 1'b1) begin
        e = sb.pop_front();
        n_checks++;
        if (match !== e.m) begin n_fails++; $display("[TB] FAIL %s match: got %b expected %0d", tag, match, e.m); end
        n_checks++;
        if (match_index !== IW'(e.idx)) begin n_fails++; $display("[TB] FAIL %s match_index: got %0d expected %0d", tag, match_index, e.idx); end
`ifdef SME_ALL_MATCH_EN
        n_checks++;
        if (match_last !== e.last) begin n_fails++; $display("[TB] FAIL %s match_last: got %b expected %0d", tag, match_last, e.last); end
`endif
        if (e.last) begin
          n_checks++;
          if (cyc > bound) begin n_fails++; $display("[TB] FAIL %s latency: got %0d cycles expected <= %0d", tag, cyc, bound); end
        end
        last_m = e.m; last_idx = e.idx;
      end
    end
    if (sb.size() > 0) begin
      n_checks++; n_fails++;
      $display("[TB] FAIL %s timeout: got %0d strobes missing expected 0", tag, sb.size());
      sb.delete();
    end
    @(negedge clk);
    n_checks++;
    if (valid !== 1'b0 || busy !== 1'b0) begin
      n_fails++;
      $display("[TB] FAIL %s after_done: got valid=%b busy=%b expected 0 0", tag, valid, busy);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    n_checks++;
    if ({valid, match, busy, overflow} !== 4'b0 || match_index !== '0) begin
      n_fails++;
      $display("[TB] FAIL %s: got valid=%b match=%b busy=%b overflow=%b index=%0d expected all 0",
               tag, valid, match, busy, overflow, match_index);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    mlen = 0; mplen = 0; movf = 0;
  endtask

  task automatic test_empty_string();
    drive_pattern("^");  expect_result(1, 0); run_search("empty_head");
    drive_pattern("a");  expect_result(0, 0); run_search("empty_char");
    drive_pattern("$");  expect_result(1, 0); run_search("empty_tail");
  endtask

  task automatic test_basic();
    drive_string("ab cd abc");
    drive_pattern("abc"); expect_result(1, 6); run_search("basic_abc");
  endtask

  task automatic test_retained();
    drive_pattern("^c.");  expect_result(1, 3); run_search("head_c_dot");
    drive_pattern("b$");   expect_result(1, 1); run_search("b_tail");
    drive_pattern("c$");   expect_result(1, 8); run_search("c_tail_end");
    drive_pattern("^ab$"); expect_result(1, 0); run_search("word_ab");
  endtask

  task automatic test_nomatch();
    drive_string("hello");
    drive_pattern("l.x");    expect_result(0, 0); run_search("nomatch_lx");
    drive_pattern("$");      expect_result(1, 4); run_search("lone_tail");
    drive_pattern("^");      expect_result(1, 0); run_search("lone_head");
    drive_pattern("hellos"); expect_result(0, 0); run_search("too_long");
  endtask

  task automatic test_overflow();
    drive_string("aaaaaaaaaaaaaaaaaaaaaaaaaaaaaaxyzz");
    n_checks++;
    if (overflow !== 1'b1) begin n_fails++; $display("[TB] FAIL str_overflow: got %b expected 1", overflow); end
    drive_pattern("xy"); expect_result(1, 30); run_search("ovf_xy");
    drive_pattern("z"); expect_result(0, 0); run_search("ovf_dropped");
    n_checks++;
    if (overflow !== 1'b1) begin n_fails++; $display("[TB] FAIL ovf_sticky: got %b expected 1", overflow); end
    drive_string("abcdefghij");
    n_checks++;
    if (overflow !== 1'b0) begin n_fails++; $display("[TB] FAIL ovf_clear: got %b expected 0", overflow); end
    drive_pattern("abcdefghZ"); expect_result(1, 0); run_search("pat_trunc");
    n_checks++;
    if (overflow !== 1'b1) begin n_fails++; $display("[TB] FAIL pat_overflow: got %b expected 1", overflow); end
  endtask

  task automatic test_all_match();
    drive_string("aa aa");
    drive_pattern("a."); expect_result(1, 0); run_search("all_a_dot");
  endtask

  task automatic test_abort();
    drive_string("ab cd abc");
    drive_pattern("b$"); expect_result(1, 1); run_search("pre_abort");
    drive_pattern("abc");
    @(negedge clk); isstring = 1'b0; ispattern = 1'b0;
    @(negedge clk);
    send_pchar("c", 1'b1);
    @(negedge clk);
    n_checks++;
    if (valid !== 1'b0 || match !== last_m || match_index !== IW'(last_idx)) begin
      n_fails++;
      $display("[TB] FAIL abort_hold: got valid=%b match=%b index=%0d expected 0 %0d %0d",
               valid, match, match_index, last_m, last_idx);
    end
    ispattern = 1'b1; chardata = "d"; mpat[1] = "d"; mplen = 2;
    expect_result(1, 3); run_search("after_abort");
  endtask

  task automatic test_reset_mid();
    drive_string("ab cd abc ab cd abc");
    drive_pattern("zz");
    @(negedge clk); ispattern = 1'b0; chardata = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_outputs("reset_mid");
    @(negedge clk);
    reset = 1'b0;
    mlen = 0; mplen = 0; movf = 0; last_m = 0; last_idx = 0;
  endtask

  task automatic test_random();
    byte alph[3];
    byte pch[3];
    int  blen;
    bit  fst;
    alph[0] = "a"; alph[1] = "b"; alph[2] = " ";
    pch[0] = "a"; pch[1] = "b"; pch[2] = ".";
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < 12; i++) send_schar(alph[$urandom_range(0, 2)], i == 0);
      @(negedge clk); isstring = 1'b0; chardata = '0;
      fst = 1;
      if ($urandom_range(0, 1) == 1) begin send_pchar(8'h5E, fst); fst = 0; end
      blen = $urandom_range(1, 3);
      for (int k = 0; k < blen; k++) begin send_pchar(pch[$urandom_range(0, 2)], fst); fst = 0; end
      if ($urandom_range(0, 1) == 1) send_pchar(8'h24, 1'b0);
      push_model();
      run_search("random");
    end
  endtask

  initial begin
    test_reset();
    test_empty_string();
    test_basic();
    test_retained();
    test_nomatch();
    test_overflow();
    test_all_match();
    test_abort();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
